// File: rtl/aud_rmm_seq.sv
// aud_rmm_seq: AUD RAM-monitor read sequencer. It turns one host request (address, word count)
// into CMD/ADDR/WAIT/DATA nibble transactions and streams the returned longwords downstream.
module aud_rmm_seq #(
  parameter int g_len_w   = 16,
  parameter int g_timeout = 1023
) (
  input  logic               clk_sys_i,
  input  logic               rst_n_i,
  input  logic               start_i,
  input  logic               abort_i,
  input  logic [31:0]        addr_i,
  input  logic [g_len_w-1:0] len_i,
  output logic               busy_o,
  output logic               done_o,
  output logic               err_o,
  output logic [1:0]         err_code_o,
  output logic [g_len_w-1:0] words_left_o,
  output logic [3:0]         tx_nib_o,
  output logic               tx_valid_o,
  input  logic               tx_ready_i,
  input  logic [3:0]         rx_nib_i,
  input  logic               rx_valid_i,
  output logic [31:0]        rd_data_o,
  output logic               rd_valid_o,
  input  logic               rd_ready_i
);

  localparam int TMO_W = (g_timeout < 1) ? 1 : $clog2(g_timeout + 1);
  localparam logic [TMO_W-1:0] TMO_RELOAD = TMO_W'(g_timeout);

  localparam logic [3:0] CMD_RD_LW = 4'b1010;
  localparam logic [3:0] STS_BUSY  = 4'b0000;
  localparam logic [3:0] STS_READY = 4'b0001;

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_TARGET  = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;
  localparam logic [1:0] ERR_ABORT   = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_WAIT,
    ST_DATA,
    ST_PUSH,
    ST_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [31:0]        addr_q;
  logic [g_len_w-1:0] words_left_q;
  logic [2:0]         idx_q;
  logic [31:0]        word_q;
  logic [TMO_W-1:0]   tmo_q;
  logic               err_q;
  logic [1:0]         code_q;
  logic               abort_q;

  logic               accept;
  logic               tx_fire;
  logic               rx_take;
  logic               push_fire;
  logic               fin_set;
  logic [1:0]         fin_code;
  logic               abort_now;
  logic               tmo_zero;
  logic               in_tx_q;
  logic               in_tx_d;

  // An abort seen while a nibble is still pending on the TX side is remembered until that nibble goes out.
  assign abort_now = abort_i | abort_q;
  assign tmo_zero  = (tmo_q == '0);
  assign in_tx_q   = (state_q == ST_CMD) || (state_q == ST_ADDR);
  assign in_tx_d   = (state_d == ST_CMD) || (state_d == ST_ADDR);

  assign err_o        = err_q;
  assign err_code_o   = code_q;
  assign words_left_o = words_left_q;
  assign rd_data_o    = word_q;

  always_ff @(posedge clk_sys_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    busy_o     = 1'b0;
    done_o     = 1'b0;
    tx_valid_o = 1'b0;
    tx_nib_o   = 4'h0;
    rd_valid_o = 1'b0;
    accept     = 1'b0;
    tx_fire    = 1'b0;
    rx_take    = 1'b0;
    push_fire  = 1'b0;
    fin_set    = 1'b0;
    fin_code   = ERR_OK;

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          accept  = 1'b1;
          state_d = (len_i == '0) ? ST_DONE : ST_CMD;
        end
      end

      ST_CMD: begin
        busy_o     = 1'b1;
        tx_valid_o = 1'b1;
        tx_nib_o   = CMD_RD_LW;
        if (tx_ready_i) begin
          tx_fire = 1'b1;
          if (abort_now) begin
            fin_set  = 1'b1;
            fin_code = ERR_ABORT;
            state_d  = ST_DONE;
          end else begin
            state_d = ST_ADDR;
          end
        end
      end

      // Address goes out most-significant nibble first; idx 0 selects addr[31:28].
      ST_ADDR: begin
        busy_o     = 1'b1;
        tx_valid_o = 1'b1;
        tx_nib_o   = addr_q[{~idx_q, 2'b00} +: 4];
        if (tx_ready_i) begin
          tx_fire = 1'b1;
          if (abort_now) begin
            fin_set  = 1'b1;
            fin_code = ERR_ABORT;
            state_d  = ST_DONE;
          end else if (idx_q == 3'd7) begin
            state_d = ST_WAIT;
          end
        end
      end

      ST_WAIT: begin
        busy_o = 1'b1;
        if (abort_now) begin
          fin_set  = 1'b1;
          fin_code = ERR_ABORT;
          state_d  = ST_DONE;
        end else if (rx_valid_i) begin
          rx_take = 1'b1;
          if (rx_nib_i == STS_READY) begin
            state_d = ST_DATA;
          end else if (rx_nib_i != STS_BUSY) begin
            fin_set  = 1'b1;
            fin_code = ERR_TARGET;
            state_d  = ST_DONE;
          end
        end else if (tmo_zero) begin
          fin_set  = 1'b1;
          fin_code = ERR_TIMEOUT;
          state_d  = ST_DONE;
        end
      end

      ST_DATA: begin
        busy_o = 1'b1;
        if (abort_now) begin
          fin_set  = 1'b1;
          fin_code = ERR_ABORT;
          state_d  = ST_DONE;
        end else if (rx_valid_i) begin
          rx_take = 1'b1;
          if (idx_q == 3'd7) begin
            state_d = ST_PUSH;
          end
        end else if (tmo_zero) begin
          fin_set  = 1'b1;
          fin_code = ERR_TIMEOUT;
          state_d  = ST_DONE;
        end
      end

      // Abort wins over a same-cycle accept so the word is never counted as delivered.
      ST_PUSH: begin
        busy_o     = 1'b1;
        rd_valid_o = 1'b1;
        if (abort_now) begin
          fin_set  = 1'b1;
          fin_code = ERR_ABORT;
          state_d  = ST_DONE;
        end else if (rd_ready_i) begin
          push_fire = 1'b1;
          state_d   = (words_left_q > g_len_w'(1)) ? ST_CMD : ST_DONE;
        end
      end

      ST_DONE: begin
        done_o  = 1'b1;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_sys_i) begin
    if (!rst_n_i) begin
      addr_q       <= '0;
      words_left_q <= '0;
      idx_q        <= '0;
      word_q       <= '0;
      tmo_q        <= '0;
      err_q        <= 1'b0;
      code_q       <= ERR_OK;
      abort_q      <= 1'b0;
    end else begin
      if (accept) begin
        addr_q       <= {addr_i[31:2], 2'b00};
        words_left_q <= len_i;
        idx_q        <= '0;
        word_q       <= '0;
        err_q        <= 1'b0;
        code_q       <= ERR_OK;
      end

      // idx wraps back to 0 after the eighth nibble, ready for the next phase.
      if (tx_fire && (state_q == ST_ADDR)) begin
        idx_q <= idx_q + 3'd1;
      end
      if (rx_take && (state_q == ST_DATA)) begin
        word_q <= {word_q[27:0], rx_nib_i};
        idx_q  <= idx_q + 3'd1;
      end

      if (push_fire) begin
        words_left_q <= words_left_q - g_len_w'(1);
        addr_q       <= addr_q + 32'd4;
      end

      if (fin_set) begin
        code_q <= fin_code;
        err_q  <= 1'b1;
      end

      // Held at reload while sending the address so WAIT starts with a full budget.
      if ((state_q == ST_ADDR) || rx_take) begin
        tmo_q <= TMO_RELOAD;
      end else if (((state_q == ST_WAIT) || (state_q == ST_DATA)) && !tmo_zero) begin
        tmo_q <= tmo_q - TMO_W'(1);
      end

      if (in_tx_q && in_tx_d) begin
        abort_q <= abort_q | abort_i;
      end else begin
        abort_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_aud_rmm_seq.sv
// tb_aud_rmm_seq: randomized and directed checks of aud_rmm_seq against a transaction-level model
// of the expected nibble traffic, returned words and completion status.
module tb_aud_rmm_seq;

  logic        clk_sys_i;
  logic        rst_n_i;
  logic        start_i;
  logic        abort_i;
  logic [31:0] addr_i;
  logic [15:0] len_i;
  logic        busy_o;
  logic        done_o;
  logic        err_o;
  logic [1:0]  err_code_o;
  logic [15:0] words_left_o;
  logic [3:0]  tx_nib_o;
  logic        tx_valid_o;
  logic        tx_ready_i;
  logic [3:0]  rx_nib_i;
  logic        rx_valid_i;
  logic [31:0] rd_data_o;
  logic        rd_valid_o;
  logic        rd_ready_i;

  int errors = 0;
  int checks = 0;

  aud_rmm_seq #(
    .g_len_w  (16),
    .g_timeout(15)
  ) dut (
    .clk_sys_i   (clk_sys_i),
    .rst_n_i     (rst_n_i),
    .start_i     (start_i),
    .abort_i     (abort_i),
    .addr_i      (addr_i),
    .len_i       (len_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .err_o       (err_o),
    .err_code_o  (err_code_o),
    .words_left_o(words_left_o),
    .tx_nib_o    (tx_nib_o),
    .tx_valid_o  (tx_valid_o),
    .tx_ready_i  (tx_ready_i),
    .rx_nib_i    (rx_nib_i),
    .rx_valid_i  (rx_valid_i),
    .rd_data_o   (rd_data_o),
    .rd_valid_o  (rd_valid_o),
    .rd_ready_i  (rd_ready_i)
  );

  initial clk_sys_i = 1'b0;
  always #5 clk_sys_i = ~clk_sys_i;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish (got timeout, required finish)");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] nibOf(input logic [31:0] w, input int i);
    logic [31:0] t;
    t = w >> (28 - 4 * i);
    return t[3:0];
  endfunction

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " busy"}, busy_o, 0);
    checkOutput({tag, " done"}, done_o, 0);
    checkOutput({tag, " err"}, err_o, 0);
    checkOutput({tag, " code"}, err_code_o, 0);
    checkOutput({tag, " words_left"}, words_left_o, 0);
    checkOutput({tag, " tx_nib"}, tx_nib_o, 0);
    checkOutput({tag, " tx_valid"}, tx_valid_o, 0);
    checkOutput({tag, " rd_data"}, rd_data_o, 0);
    checkOutput({tag, " rd_valid"}, rd_valid_o, 0);
  endtask

  // One-cycle start pulse; request inputs are scrambled afterwards to prove they were latched.
  task automatic applyStimulus(input logic [31:0] addr, input logic [15:0] len);
    start_i = 1'b1;
    addr_i  = addr;
    len_i   = len;
    @(negedge clk_sys_i);
    start_i = 1'b0;
    addr_i  = $urandom;
    len_i   = 16'($urandom);
    checkOutput("start err clr", err_o, 0);
    checkOutput("start code clr", err_code_o, 0);
    checkOutput("start words_left", words_left_o, len);
    checkOutput("start busy", busy_o, (len != 0) ? 1 : 0);
  endtask

  task automatic expectTx(input logic [3:0] exp, input string tag);
    int waited;
    int stall;
    waited = 0;
    while (!tx_valid_o && waited < 50) begin
      @(negedge clk_sys_i);
      waited++;
    end
    if (!tx_valid_o) begin
      checkOutput({tag, " tx_valid wait"}, 0, 1);
      return;
    end
    stall = $urandom_range(0, 2);
    for (int s = 0; s < stall; s++) begin
      if ($urandom_range(0, 1) == 1) begin
        rx_valid_i = 1'b1;
        rx_nib_i   = 4'($urandom);
      end
      @(negedge clk_sys_i);
      rx_valid_i = 1'b0;
      checkOutput({tag, " hold valid"}, tx_valid_o, 1);
      checkOutput({tag, " hold nib"}, tx_nib_o, exp);
    end
    checkOutput(tag, tx_nib_o, exp);
    tx_ready_i = 1'b1;
    @(negedge clk_sys_i);
    tx_ready_i = 1'b0;
  endtask

  task automatic sendHeader(input logic [31:0] word_addr);
    expectTx(4'hA, "tx cmd");
    for (int i = 0; i < 8; i++) begin
      expectTx(nibOf(word_addr, i), "tx addr");
    end
  endtask

  task automatic phyRx(input logic [3:0] nib, input int gap);
    repeat (gap) @(negedge clk_sys_i);
    rx_valid_i = 1'b1;
    rx_nib_i   = nib;
    @(negedge clk_sys_i);
    rx_valid_i = 1'b0;
    rx_nib_i   = 4'h0;
  endtask

  task automatic sendWord(input logic [31:0] data);
    for (int i = 0; i < 8; i++) begin
      phyRx(nibOf(data, i), $urandom_range(0, 5));
    end
  endtask

  task automatic takeWord(input logic [31:0] exp, input logic [15:0] left_after);
    int waited;
    int stall;
    waited = 0;
    while (!rd_valid_o && waited < 60) begin
      @(negedge clk_sys_i);
      waited++;
    end
    if (!rd_valid_o) begin
      checkOutput("rd_valid wait", 0, 1);
      return;
    end
    stall = $urandom_range(0, 3);
    for (int s = 0; s < stall; s++) begin
      @(negedge clk_sys_i);
      checkOutput("rd_valid hold", rd_valid_o, 1);
      checkOutput("rd_data hold", rd_data_o, exp);
    end
    checkOutput("rd_data", rd_data_o, exp);
    rd_ready_i = 1'b1;
    @(negedge clk_sys_i);
    rd_ready_i = 1'b0;
    checkOutput("words_left", words_left_o, left_after);
  endtask

  // Full successful request; the model expects word k at (aligned base + 4k) mod 2^32.
  task automatic runRead(input logic [31:0] addr, input int len, input int busy_n,
                         input int busy_gap, input bit fixed, input logic [31:0] fixed_word);
    logic [31:0] base;
    logic [31:0] data;
    base = {addr[31:2], 2'b00};
    applyStimulus(addr, 16'(len));
    for (int k = 0; k < len; k++) begin
      sendHeader(base + 32'(4 * k));
      for (int b = 0; b < busy_n; b++) begin
        phyRx(4'h0, (busy_gap < 0) ? $urandom_range(0, 5) : busy_gap);
      end
      phyRx(4'h1, $urandom_range(0, 5));
      data = fixed ? fixed_word : $urandom;
      sendWord(data);
      takeWord(data, 16'(len - k - 1));
      if (k < len - 1) begin
        checkOutput("mid busy", busy_o, 1);
      end
    end
    checkOutput("done pulse", done_o, 1);
    checkOutput("done busy", busy_o, 0);
    checkOutput("done err", err_o, 0);
    checkOutput("done code", err_code_o, 0);
    @(negedge clk_sys_i);
    checkOutput("done one cycle", done_o, 0);
  endtask

  initial begin
    int cnt;
    logic [31:0] data;
    rst_n_i    = 1'b0;
    start_i    = 1'b0;
    abort_i    = 1'b0;
    addr_i     = '0;
    len_i      = '0;
    tx_ready_i = 1'b0;
    rx_nib_i   = '0;
    rx_valid_i = 1'b0;
    rd_ready_i = 1'b0;
    repeat (3) @(negedge clk_sys_i);
    checkAllZero("reset");
    rst_n_i = 1'b1;
    @(negedge clk_sys_i);

    // Single word, data nibbles 1..8, unaligned address.
    runRead(32'h1000_0002, 1, 0, 0, 1'b1, 32'h1234_5678);

    // Address wrap across the top of memory.
    runRead(32'hFFFF_FFF8, 3, 1, -1, 1'b0, 32'h0);

    // Five busy statuses spaced close to the timeout budget.
    runRead(32'h0000_4000, 1, 5, 12, 1'b0, 32'h0);

    // Target error status.
    applyStimulus(32'h0000_8000, 1);
    sendHeader(32'h0000_8000);
    phyRx(4'h6, 2);
    checkOutput("tgt done", done_o, 1);
    checkOutput("tgt err", err_o, 1);
    checkOutput("tgt code", err_code_o, 2'b01);
    checkOutput("tgt rd_valid", rd_valid_o, 0);
    @(negedge clk_sys_i);
    checkOutput("tgt err sticky", err_o, 1);
    checkOutput("tgt done off", done_o, 0);

    // Timeout during DATA after three nibbles.
    applyStimulus(32'h0000_0100, 1);
    sendHeader(32'h0000_0100);
    phyRx(4'h1, 1);
    phyRx(4'h9, 0);
    phyRx(4'h8, 3);
    phyRx(4'h7, 1);
    cnt = 0;
    while (!done_o && cnt < 40) begin
      @(negedge clk_sys_i);
      cnt++;
    end
    checkOutput("tmo latency", cnt, 16);
    checkOutput("tmo code", err_code_o, 2'b10);
    checkOutput("tmo err", err_o, 1);
    @(negedge clk_sys_i);

    // Abort while PUSH is stalled by downstream.
    applyStimulus(32'h0000_0200, 2);
    sendHeader(32'h0000_0200);
    phyRx(4'h1, 0);
    data = $urandom;
    sendWord(data);
    for (int s = 0; s < 10; s++) begin
      checkOutput("stall rd_valid", rd_valid_o, 1);
      checkOutput("stall rd_data", rd_data_o, data);
      @(negedge clk_sys_i);
    end
    abort_i = 1'b1;
    @(negedge clk_sys_i);
    abort_i = 1'b0;
    checkOutput("abort rd_valid", rd_valid_o, 0);
    checkOutput("abort done", done_o, 1);
    checkOutput("abort code", err_code_o, 2'b11);
    checkOutput("abort words_left", words_left_o, 2);
    @(negedge clk_sys_i);

    // Abort during a stalled CMD nibble completes that nibble first.
    applyStimulus(32'h0000_0300, 1);
    abort_i = 1'b1;
    @(negedge clk_sys_i);
    abort_i = 1'b0;
    checkOutput("cmd abort hold valid", tx_valid_o, 1);
    checkOutput("cmd abort hold nib", tx_nib_o, 4'hA);
    checkOutput("cmd abort no done", done_o, 0);
    tx_ready_i = 1'b1;
    @(negedge clk_sys_i);
    tx_ready_i = 1'b0;
    checkOutput("cmd abort done", done_o, 1);
    checkOutput("cmd abort code", err_code_o, 2'b11);
    @(negedge clk_sys_i);

    // Abort beats a same-cycle bad status.
    applyStimulus(32'h0000_0400, 1);
    sendHeader(32'h0000_0400);
    rx_valid_i = 1'b1;
    rx_nib_i   = 4'h6;
    abort_i    = 1'b1;
    @(negedge clk_sys_i);
    rx_valid_i = 1'b0;
    abort_i    = 1'b0;
    checkOutput("abort prio done", done_o, 1);
    checkOutput("abort prio code", err_code_o, 2'b11);
    @(negedge clk_sys_i);

    // Zero-length request.
    applyStimulus(32'h0000_0500, 0);
    checkOutput("len0 done", done_o, 1);
    checkOutput("len0 tx_valid", tx_valid_o, 0);
    checkOutput("len0 code", err_code_o, 0);
    @(negedge clk_sys_i);
    checkOutput("len0 idle tx_valid", tx_valid_o, 0);

    // Start while busy is ignored.
    applyStimulus(32'h2468_ACE0, 1);
    expectTx(4'hA, "tx cmd");
    expectTx(4'h2, "tx addr");
    start_i = 1'b1;
    addr_i  = 32'h0;
    len_i   = 16'd9;
    @(negedge clk_sys_i);
    start_i = 1'b0;
    checkOutput("busy start words_left", words_left_o, 1);
    checkOutput("busy start busy", busy_o, 1);
    for (int i = 1; i < 8; i++) begin
      expectTx(nibOf(32'h2468_ACE0, i), "tx addr keep");
    end
    phyRx(4'h1, 1);
    data = $urandom;
    sendWord(data);
    takeWord(data, 0);
    checkOutput("busy start done", done_o, 1);
    @(negedge clk_sys_i);

    // Randomized successful requests.
    for (int t = 0; t < 15; t++) begin
      runRead($urandom, $urandom_range(1, 3), $urandom_range(0, 3), -1, 1'b0, 32'h0);
    end

    // Reset in the middle of the address phase.
    applyStimulus(32'hCAFE_0000, 2);
    expectTx(4'hA, "tx cmd");
    expectTx(4'hC, "tx addr");
    expectTx(4'hA, "tx addr");
    rst_n_i = 1'b0;
    @(negedge clk_sys_i);
    checkAllZero("rst mid");
    rst_n_i = 1'b1;
    @(negedge clk_sys_i);
    checkOutput("rst mid no done", done_o, 0);
    checkOutput("rst mid tx_valid", tx_valid_o, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
